// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the IO bus arbiter.
// Requesters and the bench use the port addresses from here.
package io_bus_arbiter_pkg;

   localparam int BUS_ADDR_W    = 10;
   localparam int BUS_DATA_W    = 4;
   localparam int BUS_MAX_BURST = 4;

   localparam logic [9:0] IN_PORT_ADDR  = 10'b1111111110;
   localparam logic [9:0] OUT_PORT_ADDR = 10'b1111111111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared IO bus.
// The arbiter takes the slave view; the requesters/memory the master view.
interface io_bus_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 4
);
   logic              req0, req1;
   logic              wr_en0, wr_en1;
   logic              rd_en0, rd_en1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              grant0, grant1;
   logic [DATA_W-1:0] rdata;
   logic              rvalid0, rvalid1;
   logic              bus_write_en;
   logic              bus_read_en;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;

   modport slave (
      input  req0, req1, wr_en0, wr_en1, rd_en0, rd_en1,
      input  addr0, addr1, wdata0, wdata1, bus_rdata,
      output grant0, grant1, rdata, rvalid0, rvalid1,
      output bus_write_en, bus_read_en, bus_addr, bus_wdata
   );

   modport master (
      output req0, req1, wr_en0, wr_en1, rd_en0, rd_en1,
      output addr0, addr1, wdata0, wdata1, bus_rdata,
      input  grant0, grant1, rdata, rvalid0, rvalid1,
      input  bus_write_en, bus_read_en, bus_addr, bus_wdata
   );
endinterface

// File: rtl/io_bus_mux.sv
// Owner select onto the IO bus; a write beats a simultaneous read.
// All bus outputs are zero outside a transfer cycle.
module io_bus_mux #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 4
) (
   input  logic              xfer0,
   input  logic              xfer1,
   input  logic              wr_en0,
   input  logic              wr_en1,
   input  logic              rd_en0,
   input  logic              rd_en1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              bus_write_en,
   output logic              bus_read_en,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata
);

   always_comb begin
      bus_write_en = 1'b0;
      bus_read_en  = 1'b0;
      bus_addr     = '0;
      bus_wdata    = '0;
      unique case (1'b1)
         xfer0: begin
            bus_write_en = wr_en0;
            bus_read_en  = rd_en0 & ~wr_en0;
            bus_addr     = addr0;
            bus_wdata    = wdata0;
         end
         xfer1: begin
            bus_write_en = wr_en1;
            bus_read_en  = rd_en1 & ~wr_en1;
            bus_addr     = addr1;
            bus_wdata    = wdata1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin IO bus arbiter with bounded bursts between CPU (0)
// and loader/debug (1); registered grants and read return.
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W    = BUS_ADDR_W,
   parameter int DATA_W    = BUS_DATA_W,
   parameter int MAX_BURST = BUS_MAX_BURST
) (
   input logic             clk,
   input logic             rst_n,
   io_bus_arbiter_if.slave bus
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   state_t        state, state_nx;
   logic          last, last_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          grant0, grant1;
   logic          xfer0, xfer1;

   assign grant0 = (state == OWN0);
   assign grant1 = (state == OWN1);
   assign xfer0  = grant0 & bus.req0;
   assign xfer1  = grant1 & bus.req1;

   assign bus.grant0 = grant0;
   assign bus.grant1 = grant1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         last  <= last_nx;
         cnt   <= cnt_nx;
      end
   end

   // The burst counter only advances while the other side waits.
   always_comb begin
      state_nx = state;
      last_nx  = last;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.req0 && (!bus.req1 || last)) begin
               state_nx = OWN0;
               cnt_nx   = '0;
            end else if (bus.req1) begin
               state_nx = OWN1;
               cnt_nx   = '0;
            end
         end
         OWN0: begin
            if (!bus.req0) begin
               last_nx  = 1'b0;
               state_nx = bus.req1 ? OWN1 : IDLE;
               cnt_nx   = '0;
            end else if (bus.req1) begin
               if (cnt == CNT_LAST) begin
                  last_nx  = 1'b0;
                  state_nx = OWN1;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         OWN1: begin
            if (!bus.req1) begin
               last_nx  = 1'b1;
               state_nx = bus.req0 ? OWN0 : IDLE;
               cnt_nx   = '0;
            end else if (bus.req0) begin
               if (cnt == CNT_LAST) begin
                  last_nx  = 1'b1;
                  state_nx = OWN0;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rdata   <= '0;
         bus.rvalid0 <= 1'b0;
         bus.rvalid1 <= 1'b0;
      end else begin
         bus.rvalid0 <= grant0 & bus.bus_read_en;
         bus.rvalid1 <= grant1 & bus.bus_read_en;
         if (bus.bus_read_en) bus.rdata <= bus.bus_rdata;
      end
   end

   io_bus_mux #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_mux (
      .xfer0       (xfer0),
      .xfer1       (xfer1),
      .wr_en0      (bus.wr_en0),
      .wr_en1      (bus.wr_en1),
      .rd_en0      (bus.rd_en0),
      .rd_en1      (bus.rd_en1),
      .addr0       (bus.addr0),
      .addr1       (bus.addr1),
      .wdata0      (bus.wdata0),
      .wdata1      (bus.wdata1),
      .bus_write_en(bus.bus_write_en),
      .bus_read_en (bus.bus_read_en),
      .bus_addr    (bus.bus_addr),
      .bus_wdata   (bus.bus_wdata)
   );

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single memory-mapped IO bus (10-bit address, 4-bit data, write/read enables) between two requesters. Requester 0 is the CPU core; requester 1 is the loader/debug unit.
- Sits between the requesters and the io_ports / data-memory decode.
- Round-robin arbitration with a bounded burst length, so neither side can starve the other.
- Registered grants; combinational forwarding of the owner's command onto the bus.

Parameters:
- ADDR_W, 10, bus address width
- DATA_W, 4, bus data width
- MAX_BURST, 4, max consecutive transfers by one owner while the other requester is waiting (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1 each  requester wants the bus; held high until done
- wr_en0, wr_en1  in  1 each  requester write command
- rd_en0, rd_en1  in  1 each  requester read command
- addr0, addr1  in  ADDR_W each  requester address
- wdata0, wdata1  in  DATA_W each  requester write data
- grant0, grant1  out  1 each  registered; requester owns the bus this cycle
- rdata  out  DATA_W  registered read data (shared by both requesters)
- rvalid0, rvalid1  out  1 each  rdata holds that requester's read result
- bus_write_en  out  1  to io_ports/memory
- bus_read_en  out  1  to io_ports/memory
- bus_addr  out  ADDR_W  to io_ports/memory
- bus_wdata  out  DATA_W  to io_ports/memory
- bus_rdata  in  DATA_W  from io_ports/memory; may be high-Z when unselected

Behaviour:
- States: IDLE, OWN0, OWN1. Also tracked: last_owner (1 bit) and burst_cnt (clog2(MAX_BURST) bits).
- Reset (async, rst_n low):
  - state=IDLE, last_owner=1, so req0 wins the first tie.
  - burst_cnt=0; grant0/1=0; rdata=0; rvalid0/1=0.
  - Bus outputs are 0, since they derive from state.
- Grant equals the state: grant0 = (state==OWN0), grant1 = (state==OWN1). Grant rises one cycle after req is sampled high in IDLE.
- IDLE transitions:
  - Only req0 → OWN0.
  - Only req1 → OWN1.
  - Both → the requester != last_owner.
  - Neither → stay in IDLE.
  - burst_cnt is cleared on any entry to OWNx.
- Transfer: a cycle with grantX=1 and reqX=1 is a transfer. The bus carries that requester's addr/wdata/wr_en/rd_en combinationally.
  - If wr_en and rd_en are both high, the write wins and bus_read_en=0.
  - In non-transfer cycles all bus outputs are 0.
- Read return: on a read transfer, rdata <= bus_rdata at that edge, and rvalidX=1 for exactly the next cycle. Otherwise rvalid=0 and rdata holds its value.
  - Read latency: 1 cycle after the transfer cycle.
  - Writes take effect at the transfer edge (io_ports registers them).
- OWNx transitions, per cycle:
  - reqX low → release. last_owner<=X. Go to OWN(other) if the other req is high, else IDLE.
  - reqX high, other req high, burst_cnt==MAX_BURST-1 → this cycle's transfer completes, then preempt. last_owner<=X, next state OWN(other), burst_cnt<=0.
  - Otherwise stay. burst_cnt increments only while the other requester is waiting; it holds otherwise and never wraps past MAX_BURST-1.
- Direct handover (OWN0→OWN1): grant0 falls and grant1 rises on the same edge. There are no idle or overlapping cycles; grant0 & grant1 is never 1.
- A preempted requester keeps req high and is re-granted via round-robin.
- A read in the last cycle before handover still returns rvalid to the correct requester on the next cycle.
- Reset mid-transfer: all state clears immediately and any pending rvalid is dropped.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, OWN0=2'b01, OWN1=2'b10
  - IO address constants: IN_PORT_ADDR=10'b1111111110, OUT_PORT_ADDR=10'b1111111111, so requesters and the bench agree
- One natural sub-module: io_bus_mux. It is the combinational owner-select plus write-over-read gating producing the bus_* outputs.
- The FSM, burst counter and read-return register stay in the top module.

Test Plan:
- Reset, then req0=1 alone writing wdata0=4'hA to 10'h3FF → grant0=1 one cycle later; bus_write_en=1 with bus_addr=10'h3FF, bus_wdata=4'hA; grant1 stays 0.
- req1=1 reading 10'h3FE with bus_rdata=4'h5 → grant1 next cycle; bus_read_en=1; following cycle rdata=4'h5, rvalid1=1, rvalid0=0.
- req0 and req1 both rise together right after reset → OWN0 first. Each holds req continuously with MAX_BURST=4 → grants alternate 4 cycles grant0 / 4 cycles grant1, never overlapping, no gap cycles.
- req0 alone held for 10 cycles → grant0 stays 1 all 10 cycles (no preemption without contention). req1 then rises → switch within 4 transfers.
- Requester asserts wr_en and rd_en together → bus_write_en=1, bus_read_en=0, no rvalid.
- rst_n pulsed low during OWN1 with a read in flight → grant1, rvalid1 and all bus outputs drop to 0 immediately; after release, arbitration restarts from IDLE with req0 priority.
